// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage core: operand forwarding, multi-cycle
// load-use bubbles, data-memory busy freeze with sticky watchdog, and branch flush.
module hazard_ctrl #(
  parameter int unsigned REG_AW      = 5,
  parameter int unsigned LU_BUBBLES  = 1,
  parameter int unsigned MEM_TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] rs1_d,
  input  logic [REG_AW-1:0] rs2_d,
  input  logic [REG_AW-1:0] rs1_e,
  input  logic [REG_AW-1:0] rs2_e,
  input  logic [REG_AW-1:0] rd_e,
  input  logic [REG_AW-1:0] rd_m,
  input  logic [REG_AW-1:0] rd_w,
  input  logic              reg_write_e,
  input  logic              reg_write_m,
  input  logic              reg_write_w,
  input  logic              mem_read_e,
  input  logic              pc_src_e,
  input  logic              mem_busy_m,
  output logic [1:0]        forward_ae,
  output logic [1:0]        forward_be,
  output logic              stall_f,
  output logic              stall_d,
  output logic              stall_e,
  output logic              stall_m,
  output logic              flush_d,
  output logic              flush_e,
  output logic              timeout_err
);

  localparam int unsigned LU_W = $clog2(LU_BUBBLES + 1);
  localparam int unsigned WT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [LU_W-1:0] LU_INIT = LU_W'(LU_BUBBLES - 1);
  localparam logic [WT_W-1:0] WT_MAX  = WT_W'(MEM_TIMEOUT);

  localparam logic [1:0] S_RUN      = 2'd0;
  localparam logic [1:0] S_LU_STALL = 2'd1;
  localparam logic [1:0] S_MEM_WAIT = 2'd2;

  logic [1:0]      r_state;
  logic [LU_W-1:0] r_lu_cnt;
  logic [WT_W-1:0] r_wait_cnt;
  logic            r_timeout_err;

  logic [1:0]      w_state_nxt;
  logic [LU_W-1:0] w_lu_cnt_nxt;
  logic [WT_W-1:0] w_wait_cnt_nxt;
  logic            w_timeout_nxt;
  logic            w_lu_hit;
  logic [1:0]      w_fwd_a;
  logic [1:0]      w_fwd_b;
  logic            w_stall_fd;
  logic            w_stall_em;
  logic            w_flush_d;
  logic            w_flush_e;

  assign w_lu_hit = mem_read_e & reg_write_e & (rd_e != '0) &
                    ((rd_e == rs1_d) | (rd_e == rs2_d));

  always_comb begin
    w_fwd_a = 2'b00;
    if (reg_write_m && (rd_m != '0) && (rd_m == rs1_e))      w_fwd_a = 2'b01;
    else if (reg_write_w && (rd_w != '0) && (rd_w == rs1_e)) w_fwd_a = 2'b10;
    w_fwd_b = 2'b00;
    if (reg_write_m && (rd_m != '0) && (rd_m == rs2_e))      w_fwd_b = 2'b01;
    else if (reg_write_w && (rd_w != '0) && (rd_w == rs2_e)) w_fwd_b = 2'b10;
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_lu_cnt_nxt   = r_lu_cnt;
    w_wait_cnt_nxt = r_wait_cnt;
    w_timeout_nxt  = r_timeout_err;
    w_stall_fd     = 1'b0;
    w_stall_em     = 1'b0;
    w_flush_d      = 1'b0;
    w_flush_e      = 1'b0;
    case (r_state)
      S_LU_STALL: begin
        if (mem_busy_m) begin
          w_stall_fd     = 1'b1;
          w_stall_em     = 1'b1;
          w_state_nxt    = S_MEM_WAIT;
          w_wait_cnt_nxt = WT_W'(1);
        end else begin
          w_stall_fd = 1'b1;
          w_flush_e  = 1'b1;
          if (r_lu_cnt <= LU_W'(1)) begin
            w_lu_cnt_nxt = '0;
            w_state_nxt  = S_RUN;
          end else begin
            w_lu_cnt_nxt = r_lu_cnt - LU_W'(1);
          end
        end
      end
      S_MEM_WAIT: begin
        if (mem_busy_m) begin
          w_stall_fd = 1'b1;
          w_stall_em = 1'b1;
          if (r_wait_cnt != WT_MAX) w_wait_cnt_nxt = r_wait_cnt + WT_W'(1);
          if (w_wait_cnt_nxt == WT_MAX) w_timeout_nxt = 1'b1;
        end else begin
          w_wait_cnt_nxt = '0;
          w_state_nxt    = S_RUN;
          if (pc_src_e) begin
            w_flush_d = 1'b1;
            w_flush_e = 1'b1;
          end else if (w_lu_hit) begin
            w_stall_fd = 1'b1;
            w_flush_e  = 1'b1;
            if (LU_BUBBLES > 1) begin
              w_state_nxt  = S_LU_STALL;
              w_lu_cnt_nxt = LU_INIT;
            end
          end
          // bubbles frozen by the memory wait resume and outrank a fresh load-use count
          if (r_lu_cnt != '0) begin
            w_state_nxt  = S_LU_STALL;
            w_lu_cnt_nxt = r_lu_cnt;
          end
        end
      end
      default: begin
        if (mem_busy_m) begin
          w_stall_fd     = 1'b1;
          w_stall_em     = 1'b1;
          w_state_nxt    = S_MEM_WAIT;
          w_wait_cnt_nxt = WT_W'(1);
        end else if (pc_src_e) begin
          w_flush_d = 1'b1;
          w_flush_e = 1'b1;
        end else if (w_lu_hit) begin
          w_stall_fd = 1'b1;
          w_flush_e  = 1'b1;
          if (LU_BUBBLES > 1) begin
            w_state_nxt  = S_LU_STALL;
            w_lu_cnt_nxt = LU_INIT;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_RUN;
      r_lu_cnt      <= '0;
      r_wait_cnt    <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_lu_cnt      <= w_lu_cnt_nxt;
      r_wait_cnt    <= w_wait_cnt_nxt;
      r_timeout_err <= w_timeout_nxt;
    end
  end

  assign forward_ae  = w_fwd_a & {2{rst_n}};
  assign forward_be  = w_fwd_b & {2{rst_n}};
  assign stall_f     = w_stall_fd & rst_n;
  assign stall_d     = w_stall_fd & rst_n;
  assign stall_e     = w_stall_em & rst_n;
  assign stall_m     = w_stall_em & rst_n;
  assign flush_d     = w_flush_d & rst_n;
  assign flush_e     = w_flush_e & rst_n;
  assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl (LU_BUBBLES=2, MEM_TIMEOUT=4): table of single-cycle vectors
// plus hand-built multi-cycle sequences, all checked through an expected-value queue.
module tb_hazard_ctrl;

  // observed vector layout: {fa[1:0], fb[1:0], sf, sd, se, sm, fd, fe, terr}
  localparam logic [6:0] O_NONE = 7'b0000000;
  localparam logic [6:0] O_LU   = 7'b1100010;
  localparam logic [6:0] O_BR   = 7'b0000110;
  localparam logic [6:0] O_MEM  = 7'b1111000;
  localparam logic [6:0] O_TE   = 7'b0000001;

  typedef struct {
    string      name;
    logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
    logic       we_e, we_m, we_w, mrd, pc, busy;
    logic [10:0] exp;
  } vec_t;

  typedef struct {
    string       name;
    logic [10:0] exp;
  } sb_t;

  logic       clk, rst_n;
  logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
  logic       reg_write_e, reg_write_m, reg_write_w, mem_read_e, pc_src_e, mem_busy_m;
  logic [1:0] forward_ae, forward_be;
  logic       stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, timeout_err;

  int unsigned checks   = 0;
  int unsigned failures = 0;
  sb_t         sb[$];
  vec_t        tbl[15];

  hazard_ctrl #(.REG_AW(5), .LU_BUBBLES(2), .MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_e(rs1_e), .rs2_e(rs2_e),
    .rd_e(rd_e), .rd_m(rd_m), .rd_w(rd_w),
    .reg_write_e(reg_write_e), .reg_write_m(reg_write_m), .reg_write_w(reg_write_w),
    .mem_read_e(mem_read_e), .pc_src_e(pc_src_e), .mem_busy_m(mem_busy_m),
    .forward_ae(forward_ae), .forward_be(forward_be),
    .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e), .stall_m(stall_m),
    .flush_d(flush_d), .flush_e(flush_e), .timeout_err(timeout_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got=running required=finished");
    $fatal(1, "time limit");
  end

  function automatic logic [10:0] got_vec();
    return {forward_ae, forward_be, stall_f, stall_d, stall_e, stall_m,
            flush_d, flush_e, timeout_err};
  endfunction

  function automatic vec_t mk(string n, logic [4:0] r1e, logic [4:0] r2e,
                              logic [4:0] rdm, logic [4:0] rdw, logic wm, logic ww,
                              logic lu, logic pc, logic busy, logic [10:0] e);
    vec_t v;
    v.name = n;
    v.rs1_e = r1e; v.rs2_e = r2e; v.rd_m = rdm; v.rd_w = rdw;
    v.we_m = wm; v.we_w = ww;
    v.rs1_d = 5'd0; v.rs2_d = lu ? 5'd7 : 5'd0;
    v.rd_e  = lu ? 5'd7 : 5'd0;
    v.we_e  = lu; v.mrd = lu;
    v.pc = pc; v.busy = busy; v.exp = e;
    return v;
  endfunction

  task automatic chk(input string n, input logic [10:0] got, input logic [10:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%b required=%b", n, got, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    rs1_d = v.rs1_d; rs2_d = v.rs2_d; rs1_e = v.rs1_e; rs2_e = v.rs2_e;
    rd_e = v.rd_e; rd_m = v.rd_m; rd_w = v.rd_w;
    reg_write_e = v.we_e; reg_write_m = v.we_m; reg_write_w = v.we_w;
    mem_read_e = v.mrd; pc_src_e = v.pc; mem_busy_m = v.busy;
  endtask

  // drive at posedge+1, compare at the following negedge, end at next posedge+1
  task automatic run_vec(input vec_t v);
    sb_t s;
    drive(v);
    sb.push_back('{name: v.name, exp: v.exp});
    @(negedge clk);
    if (sb.size() == 0) begin
      checks++; failures++;
      $display("FAIL %s: got=empty_queue required=entry", v.name);
    end else begin
      s = sb.pop_front();
      chk(s.name, got_vec(), s.exp);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input string n, input logic [6:0] ctl);
    run_vec(mk(n, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, {4'b0000, ctl}));
  endtask

  initial begin
    tbl[0]  = mk("fwd_m_prio", 5'd5, 5'd0, 5'd5, 5'd5, 1, 1, 0, 0, 0, {2'b01, 2'b00, O_NONE});
    tbl[1]  = mk("fwd_w",      5'd5, 5'd0, 5'd5, 5'd5, 0, 1, 0, 0, 0, {2'b10, 2'b00, O_NONE});
    tbl[2]  = mk("fwd_rs0",    5'd0, 5'd0, 5'd5, 5'd5, 1, 1, 0, 0, 0, {2'b00, 2'b00, O_NONE});
    tbl[3]  = mk("fwd_rdm0",   5'd3, 5'd0, 5'd0, 5'd3, 1, 1, 0, 0, 0, {2'b10, 2'b00, O_NONE});
    tbl[4]  = mk("fwd_b_m",    5'd9, 5'd9, 5'd9, 5'd2, 1, 1, 0, 0, 0, {2'b01, 2'b01, O_NONE});
    tbl[5]  = mk("fwd_b_w",    5'd1, 5'd4, 5'd6, 5'd4, 1, 1, 0, 0, 0, {2'b00, 2'b10, O_NONE});
    tbl[6]  = mk("fwd_w_off",  5'd4, 5'd0, 5'd0, 5'd4, 1, 0, 0, 0, 0, {2'b00, 2'b00, O_NONE});
    tbl[7]  = mk("branch",     5'd0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0, {4'b0000, O_BR});
    tbl[8]  = mk("br_vs_lu",   5'd0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 1, 0, {4'b0000, O_BR});
    tbl[9]  = mk("after_br",   5'd0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, {4'b0000, O_NONE});
    tbl[10] = mk("lu_rd0",     5'd0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 0, {4'b0000, O_NONE});
    tbl[10].rd_e = 5'd0; tbl[10].rs2_d = 5'd0;
    tbl[11] = mk("lu_no_we",   5'd0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 0, {4'b0000, O_NONE});
    tbl[11].we_e = 1'b0;
    tbl[12] = mk("lu_rs1",     5'd0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 0, {4'b0000, O_LU});
    tbl[12].rs1_d = 5'd7; tbl[12].rs2_d = 5'd0;
    tbl[13] = mk("lu_bubble2", 5'd0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, {4'b0000, O_LU});
    tbl[14] = mk("lu_done",    5'd0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, {4'b0000, O_NONE});

    // reset held with busy, branch and forwarding matches present: everything must read 0
    rst_n = 1'b0;
    drive(mk("rst", 5'd5, 5'd5, 5'd5, 5'd5, 1, 1, 1, 1, 1, '0));
    #3 chk("reset_hold", got_vec(), 11'd0);
    @(negedge clk);
    chk("reset_edge", got_vec(), 11'd0);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int unsigned i = 0; i < 15; i++) run_vec(tbl[i]);

    // load-use, two bubbles (lu_hit held for the first cycle only)
    run_vec(mk("lu2_c1", 5'd0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 0, {4'b0000, O_LU}));
    idle("lu2_c2", O_LU);
    idle("lu2_c3", O_NONE);

    // memory freeze during LU_STALL with one bubble pending
    run_vec(mk("frz_lu", 5'd0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 0, {4'b0000, O_LU}));
    for (int unsigned i = 0; i < 3; i++)
      run_vec(mk("frz_busy", 5'd0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1, {4'b0000, O_MEM}));
    idle("frz_release", O_NONE);
    idle("frz_bubble", O_LU);
    idle("frz_done", O_NONE);

    // branch held in Execute during a memory wait acts on the release cycle only
    run_vec(mk("brw_busy1", 5'd0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 1, {4'b0000, O_MEM}));
    run_vec(mk("brw_busy2", 5'd0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 1, {4'b0000, O_MEM}));
    run_vec(mk("brw_release", 5'd0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0, {4'b0000, O_BR}));
    idle("brw_done", O_NONE);

    // watchdog: error visible from the 5th busy cycle onward, sticky after busy drops
    for (int unsigned i = 0; i < 6; i++)
      run_vec(mk("wdg_busy", 5'd0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1,
                 {4'b0000, (i >= 4) ? (O_MEM | O_TE) : O_MEM}));
    idle("wdg_release", O_TE);
    idle("wdg_sticky", O_TE);

    // async reset mid-MEM_WAIT, between clock edges
    run_vec(mk("arst_busy1", 5'd0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1, {4'b0000, O_MEM | O_TE}));
    drive(mk("arst_busy2", 5'd5, 5'd0, 5'd5, 5'd0, 1, 0, 0, 0, 1, '0));
    #1 chk("arst_pre", got_vec(), {2'b01, 2'b00, O_MEM | O_TE});
    rst_n = 1'b0;
    #1 chk("arst_low", got_vec(), 11'd0);
    #1 rst_n = 1'b1;
    drive(mk("arst_clr", 5'd0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, '0));
    @(posedge clk);
    #1;
    idle("arst_run", O_NONE);
    for (int unsigned i = 0; i < 3; i++)
      run_vec(mk("arst_wait_clr", 5'd0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1, {4'b0000, O_MEM}));
    idle("arst_no_te", O_NONE);

    // async reset mid-LU_STALL drops the pending bubble
    run_vec(mk("arst_lu", 5'd0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 0, {4'b0000, O_LU}));
    drive(mk("arst_lu_idle", 5'd0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, '0));
    #1 chk("arst_lu_pre", got_vec(), {4'b0000, O_LU});
    rst_n = 1'b0;
    #1 chk("arst_lu_low", got_vec(), 11'd0);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    idle("arst_lu_gone", O_NONE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
